fir_sample_chain: RTL and testbench

Self-contained sample-rate filter stage for the ADC-to-DAC signal path. It generates the system sample strobe and captures one unsigned ADC sample per strobe into a TAPS-deep delay line. It then runs a time-multiplexed multiply-accumulate over runtime-loadable signed coefficients. The result is scaled, offset and saturated to an unsigned DAC code, ready for the serial DAC driver. It replaces the vendor FIR IP and the hand-coded `+0x800` output arithmetic with one parametrised block.

---
 rtl/fir_sample_chain.sv | 158 +++++++++++++++
 tb/tb_fir_sample_chain.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_chain.sv
// fir_sample_chain: sample-rate FIR stage between the ADC and the serial DAC.
// Generates the sample strobe, captures one ADC sample per strobe into a
// TAPS-deep delay line, runs a one-tap-per-clock multiply-accumulate over
// runtime-loadable signed coefficients, then shifts, offsets and clips the
// accumulator into an unsigned DAC code.
//
// Output handshake: out_valid is a one-cycle pulse with no back-pressure
// (there is no ready). The consumer takes out_data in the cycle out_valid is
// high; out_data then holds its value until the next out_valid pulse.
module fir_sample_chain #(
    parameter int DATA_W        = 12,
    parameter int COEF_W        = 16,
    parameter int TAPS          = 16,
    parameter int ACC_W         = 36,
    parameter int SAMPLE_FACTOR = 10000,
    parameter int OUT_SHIFT     = 14,
    parameter int OUT_OFFSET    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     bypass,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic                     sample_strobe,
    output logic                     busy,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic                     overrun,
    output logic [1:0]               dbg_state
);

    localparam int XW    = DATA_W + 1;          // sample widened to a signed value
    localparam int PW    = XW + COEF_W;         // full-precision product width
    localparam int IW    = $clog2(TAPS);
    localparam int CNT_W = $clog2(SAMPLE_FACTOR);

    localparam logic [CNT_W-1:0]         DIV_LAST = CNT_W'(SAMPLE_FACTOR - 1);
    localparam logic [IW-1:0]            IDX_LAST = IW'(TAPS - 1);
    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(longint'(1) << OUT_SHIFT);
    localparam logic signed [ACC_W:0]    OUT_MAX  = (ACC_W + 1)'((longint'(1) << DATA_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                     state;
    logic [CNT_W-1:0]           div_cnt;
    logic [IW-1:0]              idx;
    logic                       byp_q;
    logic signed [ACC_W-1:0]    acc;
    logic signed [XW-1:0]       x_line [TAPS];
    logic signed [COEF_W-1:0]   coef   [TAPS];

    logic signed [PW-1:0]       prod;
    logic signed [ACC_W-1:0]    acc_sh;
    logic signed [ACC_W:0]      r_full;
    logic [DATA_W-1:0]          clip_val;

    assign sample_strobe = (div_cnt == DIV_LAST);
    assign busy          = (state != S_IDLE);
    assign dbg_state     = state;

    // Operands are sign-extended to the product width first; the true product
    // always fits, so truncating the wider multiply loses nothing.
    assign prod   = PW'(coef[idx]) * PW'(x_line[idx]);
    assign acc_sh = acc >>> OUT_SHIFT;
    assign r_full = (ACC_W + 1)'(acc_sh) + (ACC_W + 1)'(OUT_OFFSET);

    // Clip the scaled, offset result into the unsigned DAC code range.
    always_comb begin
        clip_val = r_full[DATA_W-1:0];
        if (r_full[ACC_W]) begin
            clip_val = '0;
        end else if (r_full > OUT_MAX) begin
            clip_val = '1;
        end
    end

    // Free-running sample divider; the strobe is the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Coefficient bank: resets to a unity tap 0, writable only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
            end
            coef[0] <= COEF_ONE;
        end else if (coef_we && (state == S_IDLE)) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Sample FSM: capture on strobe, one MAC per clock, then register output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            byp_q     <= 1'b0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_line[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            // A strobe landing mid-computation is dropped; only the flag records it.
            if (sample_strobe && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (sample_strobe) begin
                        x_line[0] <= {1'b0, in_data};
                        for (int i = 1; i < TAPS; i++) begin
                            x_line[i] <= x_line[i-1];
                        end
                        byp_q <= bypass;
                        acc   <= '0;
                        idx   <= '0;
                        state <= bypass ? S_OUT : S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (idx == IDX_LAST) begin
                        state <= S_OUT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_OUT: begin
                    out_data  <= byp_q ? x_line[0][DATA_W-1:0] : clip_val;
                    out_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sample_chain.sv
// Testbench for fir_sample_chain: table-driven directed vectors, hand-written
// reset/overrun sequences and randomized samples against a reference model.
module tb_fir_sample_chain;

    localparam int DW    = 12;
    localparam int TAPS  = 4;
    localparam int SF    = 32;
    localparam int SHIFT = 14;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    // ---------------- main DUT (TAPS=4, SF=32) ----------------
    logic [DW-1:0] in_data = '0;
    logic          bypass = 1'b0;
    logic          coef_we = 1'b0;
    logic [1:0]    coef_addr = '0;
    logic [15:0]   coef_data = '0;
    logic          sample_strobe, busy, out_valid, overrun;
    logic [DW-1:0] out_data;
    logic [1:0]    dbg_state;

    fir_sample_chain #(
        .DATA_W(DW), .COEF_W(16), .TAPS(TAPS), .ACC_W(36),
        .SAMPLE_FACTOR(SF), .OUT_SHIFT(SHIFT), .OUT_OFFSET(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .bypass(bypass),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .sample_strobe(sample_strobe), .busy(busy), .out_data(out_data),
        .out_valid(out_valid), .overrun(overrun), .dbg_state(dbg_state)
    );

    // ---------------- offset DUT (OUT_OFFSET=2048) ----------------
    logic [DW-1:0] off_in = 12'd3000;
    logic          off_strobe, off_busy, off_valid, off_overrun;
    logic [DW-1:0] off_data;
    logic [1:0]    off_dbg;

    fir_sample_chain #(
        .DATA_W(DW), .COEF_W(16), .TAPS(TAPS), .ACC_W(36),
        .SAMPLE_FACTOR(SF), .OUT_SHIFT(SHIFT), .OUT_OFFSET(2048)
    ) dut_off (
        .clk(clk), .rst_n(rst_n), .in_data(off_in), .bypass(1'b0),
        .coef_we(1'b0), .coef_addr(2'd0), .coef_data(16'd0),
        .sample_strobe(off_strobe), .busy(off_busy), .out_data(off_data),
        .out_valid(off_valid), .overrun(off_overrun), .dbg_state(off_dbg)
    );

    // ---------------- overrun DUT (TAPS=16, SF=8) ----------------
    logic [DW-1:0] ovr_in = 12'd5;
    logic          ovr_strobe, ovr_busy, ovr_valid, ovr_overrun;
    logic [DW-1:0] ovr_data;
    logic [1:0]    ovr_dbg;

    fir_sample_chain #(
        .DATA_W(DW), .COEF_W(16), .TAPS(16), .ACC_W(36),
        .SAMPLE_FACTOR(8), .OUT_SHIFT(SHIFT), .OUT_OFFSET(0)
    ) dut_ovr (
        .clk(clk), .rst_n(rst_n), .in_data(ovr_in), .bypass(1'b0),
        .coef_we(1'b0), .coef_addr(4'd0), .coef_data(16'd0),
        .sample_strobe(ovr_strobe), .busy(ovr_busy), .out_data(ovr_data),
        .out_valid(ovr_valid), .overrun(ovr_overrun), .dbg_state(ovr_dbg)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];   // expected DAC codes, oldest first

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Filter output = clip(floor(sum(coef[i]*hist[i]) / 2^SHIFT), 0, 4095),
    // hist[0] being the newest accepted sample.
    int coef_m [TAPS];
    int hist_m [TAPS];

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) begin
            coef_m[i] = 0;
            hist_m[i] = 0;
        end
        coef_m[0] = 1 << SHIFT;
    endfunction

    function automatic void model_push(input int x);
        for (int i = TAPS - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
        hist_m[0] = x;
    endfunction

    function automatic int model_out();
        longint sum = 0;
        longint q;
        for (int i = 0; i < TAPS; i++) sum += longint'(coef_m[i]) * longint'(hist_m[i]);
        q = sum >>> SHIFT;
        if (q < 0)    return 0;
        if (q > 4095) return 4095;
        return int'(q);
    endfunction

    // ---------------- driver tasks ----------------
    int last_s   = -1;
    int prev_out = 0;

    task automatic write_coef(input int a, input int d);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 2'(a);
        coef_data = 16'(d);
        @(negedge clk);
        coef_we = 1'b0;
        coef_m[a] = d;
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (sample_strobe) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("strobe_timeout", 32'd0, 32'd1);
        end else begin
            if (last_s >= 0) check("strobe_period", 32'(edges - last_s), 32'(SF));
            last_s = edges;
        end
    endtask

    // Apply one sample; exp < 0 means take the expected value from the model.
    // When wb is set, a coefficient write is attempted while the DUT is busy.
    task automatic run_sample(input int din, input int byp, input int exp_in,
                              input int wb, input int wa, input int wd);
        bit ok;
        int lat;
        int exp_v;
        in_data = 12'(din);
        bypass  = byp[0];
        wait_strobe(ok);
        if (!ok) return;
        model_push(din);
        if (exp_in >= 0)  exp_v = exp_in;
        else if (byp != 0) exp_v = din;
        else              exp_v = model_out();
        exp_q.push_back(12'(exp_v));
        lat = (byp != 0) ? 2 : TAPS + 2;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1 && wb != 0) begin
                coef_we   = 1'b1;
                coef_addr = 2'(wa);
                coef_data = 16'(wd);
            end
            if (k == 2) coef_we = 1'b0;
            check("busy", 32'(busy), 32'(k < lat));
            if (k < lat) begin
                check("valid_early", 32'(out_valid), 32'd0);
                check("out_hold", 32'(out_data), 32'(prev_out));
            end else begin
                check("valid_at_latency", 32'(out_valid), 32'd1);
                check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
        @(negedge clk);
        check("valid_pulse_width", 32'(out_valid), 32'd0);
        prev_out = exp_v;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int op;    // 0 = sample, 1 = coefficient write while idle
        int din;   // sample value, or coefficient address for op 1
        int byp;
        int exp;   // expected out_data, -1 = reference model
        int wb;    // attempt a write while busy
        int wa;    // address / data for busy write or idle write
        int wd;
    } vec_t;

    vec_t tbl[$];

    function automatic void add_s(input int din, input int byp, input int exp);
        tbl.push_back('{0, din, byp, exp, 0, 0, 0});
    endfunction
    function automatic void add_w(input int a, input int d);
        tbl.push_back('{1, 0, 0, 0, 0, a, d});
    endfunction
    function automatic void add_sb(input int din, input int exp, input int a, input int d);
        tbl.push_back('{0, din, 0, exp, 1, a, d});
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    // ---------------- main test ----------------
    initial begin
        int nvalid;
        bit ok;

        // Identity at reset, delay line preloaded with 1000s by the first phase.
        add_s(1000, 0, 1000); add_s(1000, 0, 1000); add_s(1000, 0, 1000);
        // Four-tap moving average: flush with zeros, then a step to 4000.
        add_w(0, 4096); add_w(1, 4096); add_w(2, 4096); add_w(3, 4096);
        add_s(0, 0, 750);  add_s(0, 0, 500);  add_s(0, 0, 250);  add_s(0, 0, 0);
        add_s(4000, 0, 1000); add_s(4000, 0, 2000); add_s(4000, 0, 3000);
        add_s(4000, 0, 4000); add_s(4000, 0, 4000);
        // Saturation low and high, then back to identity.
        add_w(0, -16384); add_w(1, 0); add_w(2, 0); add_w(3, 0);
        add_s(100, 0, 0);
        add_w(0, 32767);
        add_s(4095, 0, 4095);
        add_w(0, 16384);
        add_s(1234, 0, 1234);
        // Write gating: busy write ignored, idle write applies next sample.
        add_sb(2000, 2000, 1, 16384);
        add_s(500, 0, 500);
        add_w(1, 16384);
        add_s(300, 0, 800);
        add_w(1, 0);
        // Bypass ignores a non-unity filter.
        add_w(0, 8192);
        add_s(12'hABC, 1, 12'hABC);
        add_s(1000, 0, 500);
        add_w(0, 16384);

        // -------- reset state --------
        model_reset();
        in_data = 12'd1000;
        repeat (3) @(negedge clk);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_strobe", 32'(sample_strobe), 32'd0);

        // -------- first strobe timing, offset and overrun instances --------
        rst_n = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 15) check("ovr_before_2nd_strobe", 32'(ovr_overrun), 32'd0);
            if (n == 16) check("ovr_after_2nd_strobe", 32'(ovr_overrun), 32'd1);
            if (n == 30) check("strobe_not_early", 32'(sample_strobe), 32'd0);
            if (n == 31) begin
                check("first_strobe", 32'(sample_strobe), 32'd1);
                last_s = edges;
            end
            if (n == 32) check("busy_s1", 32'(busy), 32'd1);
            if (n == 36) begin
                check("valid_s5", 32'(out_valid), 32'd0);
                check("busy_s5", 32'(busy), 32'd1);
            end
            if (n == 37) begin
                check("valid_s6", 32'(out_valid), 32'd1);
                check("ident_first", 32'(out_data), 32'd1000);
                check("busy_s6", 32'(busy), 32'd0);
                check("offset_valid", 32'(off_valid), 32'd1);
                check("offset_sat", 32'(off_data), 32'd4095);
            end
            if (n == 40) check("ovr_sticky", 32'(ovr_overrun), 32'd1);
        end
        model_push(1000);
        prev_out = 1000;

        // -------- directed table --------
        foreach (tbl[i]) begin
            if (tbl[i].op == 1) write_coef(tbl[i].wa, tbl[i].wd);
            else run_sample(tbl[i].din, tbl[i].byp, tbl[i].exp, tbl[i].wb, tbl[i].wa, tbl[i].wd);
        end

        // -------- randomized samples against the model --------
        for (int r = 0; r < 16; r++) begin
            int nw;
            nw = int'($urandom_range(0, 2));
            for (int w = 0; w < nw; w++) begin
                int a, d;
                a = int'($urandom_range(0, TAPS - 1));
                if ($urandom_range(0, 1) == 0) d = int'($urandom_range(0, 16384)) - 8192;
                else                           d = int'($urandom_range(0, 65535)) - 32768;
                write_coef(a, d);
            end
            run_sample(int'($urandom_range(0, 4095)), ($urandom_range(0, 7) == 0) ? 1 : 0,
                       -1, 0, 0, 0);
        end
        check("main_no_overrun", 32'(overrun), 32'd0);

        // -------- reset in the middle of a MAC --------
        write_coef(0, 8192);
        in_data = 12'd3000;
        bypass  = 1'b0;
        wait_strobe(ok);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ovr_cleared", 32'(ovr_overrun), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        last_s   = -1;
        prev_out = 0;
        exp_q.delete();
        // Tap 3 now sees the oldest slot, which must have been cleared too.
        write_coef(3, 16384);
        nvalid = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) nvalid++;
        end
        check("no_valid_after_abort", 32'(nvalid), 32'd0);
        run_sample(777, 0, 777, 0, 0, 0);
        run_sample(10, 0, 10, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
